// File: rtl/axi_rd_arbiter_if.sv
// AXI4 read-only (AR + R) channel bundle between the arbiter and the shared slave port.
interface axi_rd_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [3:0]            arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;
    logic [3:0]            rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read port among NUM_CORES requesters,
// one INCR burst in flight at a time, with burst length / ID checking.
module axi_rd_arbiter #(
    parameter int NUM_CORES  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_CORES-1:0]            req_valid,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_CORES*8-1:0]          req_len,
    output logic [NUM_CORES-1:0]            req_ready,
    output logic [NUM_CORES-1:0]            rsp_valid,
    input  logic [NUM_CORES-1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0]           rsp_data,
    output logic                            rsp_last,
    output logic                            rsp_err,
    axi_rd_arbiter_if.master                m_axi,
    output logic                            busy,
    output logic [3:0]                      grant_id,
    output logic                            proto_err
);
    localparam int PW = $clog2(NUM_CORES);
    localparam logic [2:0] ARSIZE = 3'($clog2(DATA_WIDTH/8));

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

    state_e                state_q, state_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [PW-1:0]         gnt_q, gnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  arvalid_q, arvalid_d;
    logic                  err_q, err_d;

    logic                  found;
    logic [PW-1:0]         win;
    logic [PW-1:0]         idx_v;
    int                    idx;
    logic                  rready;
    logic                  r_hs;

    // Search from ptr upward with wrap; the first requester seen wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        idx_v = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_CORES) idx = idx - NUM_CORES;
            idx_v = PW'(idx);
            if (!found && req_valid[idx_v]) begin
                found = 1'b1;
                win   = idx_v;
            end
        end
    end

    assign rready = (state_q == DATA) && rsp_ready[gnt_q];
    assign r_hs   = m_axi.rvalid && rready;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                if (m_axi.rvalid) err_d = 1'b1;
                if (found) begin
                    req_ready[win] = 1'b1;
                    gnt_d   = win;
                    addr_d  = req_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
                    len_d   = req_len[int'(win)*8 +: 8];
                    ptr_d   = (win == PW'(NUM_CORES-1)) ? '0 : win + PW'(1);
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (m_axi.rvalid) err_d = 1'b1;
                if (arvalid_q && m_axi.arready) begin
                    cnt_d   = 8'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (r_hs) begin
                    cnt_d = cnt_q + 8'd1;
                    // Bad ID, early last and missing last all latch the sticky flag.
                    if (m_axi.rid != 4'(gnt_q)) err_d = 1'b1;
                    if (m_axi.rlast != (cnt_q == len_q)) err_d = 1'b1;
                    if (m_axi.rlast) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign arvalid_d = (state_d == ADDR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            arvalid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            arvalid_q <= arvalid_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state_q == DATA) rsp_valid[gnt_q] = m_axi.rvalid;
    end

    assign rsp_data = m_axi.rdata;
    assign rsp_last = m_axi.rlast;
    assign rsp_err  = m_axi.rresp[1];

    assign m_axi.arid    = 4'(gnt_q);
    assign m_axi.araddr  = addr_q;
    assign m_axi.arlen   = len_q;
    assign m_axi.arsize  = ARSIZE;
    assign m_axi.arburst = 2'b01;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready;

    assign busy      = (state_q != IDLE);
    assign grant_id  = 4'(gnt_q);
    assign proto_err = err_q;
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: the bench plays the AXI slave and checks every step.
module tb_axi_rd_arbiter;
    localparam int NC = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NC-1:0]   req_valid = '0;
    logic [NC*AW-1:0] req_addr = '0;
    logic [NC*8-1:0] req_len = '0;
    logic [NC-1:0]   req_ready;
    logic [NC-1:0]   rsp_valid;
    logic [NC-1:0]   rsp_ready = '1;
    logic [DW-1:0]   rsp_data;
    logic            rsp_last;
    logic            rsp_err;
    logic            busy;
    logic [3:0]      grant_id;
    logic            proto_err;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    axi_rd_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    axi_rd_arbiter #(.NUM_CORES(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .rsp_err   (rsp_err),
        .m_axi     (axi),
        .busy      (busy),
        .grant_id  (grant_id),
        .proto_err (proto_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] oh(input int c);
        return 4'(1 << c);
    endfunction

    task automatic reset_dut();
        @(negedge clk);
        rst_n       = 1'b0;
        req_valid   = '0;
        rsp_ready   = '1;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rlast   = 1'b0;
        axi.rid     = 4'd0;
        axi.rresp   = 2'b00;
        axi.rdata   = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Grant cycle then ADDR cycle; arready is left high so AR completes on the next edge.
    task automatic do_ar(input logic [3:0] mask, input int core, input logic [31:0] addr,
                         input logic [7:0] len);
        @(negedge clk);
        req_valid = mask;
        for (int i = 0; i < NC; i++) begin
            req_addr[i*AW +: AW] = addr;
            req_len[i*8 +: 8]    = len;
        end
        #1 chk("req_ready_grant", req_ready, oh(core));
        @(negedge clk);
        req_valid   = '0;
        axi.arready = 1'b1;
        #1;
        chk("arvalid", axi.arvalid, 1'b1);
        chk("arid", axi.arid, core);
        chk("araddr", axi.araddr, addr);
        chk("arlen", axi.arlen, len);
        chk("busy_addr", busy, 1'b1);
        chk("grant_id", grant_id, core);
        chk("req_ready_addr", req_ready, 4'b0);
    endtask

    task automatic beat(input int core, input logic [3:0] rid, input logic [31:0] data,
                        input logic last, input logic [1:0] resp, input logic rdy);
        @(negedge clk);
        axi.arready = 1'b0;
        axi.rvalid  = 1'b1;
        axi.rid     = rid;
        axi.rdata   = data;
        axi.rlast   = last;
        axi.rresp   = resp;
        rsp_ready   = rdy ? 4'hF : ~oh(core);
        #1;
        chk("rsp_valid", rsp_valid, oh(core));
        chk("rsp_data", rsp_data, data);
        chk("rsp_last", rsp_last, last);
        chk("rsp_err", rsp_err, resp[1]);
        chk("rready", axi.rready, rdy);
        chk("arvalid_data", axi.arvalid, 1'b0);
    endtask

    task automatic idle_chk(input logic exp_err);
        @(negedge clk);
        req_valid   = '0;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rlast   = 1'b0;
        axi.rresp   = 2'b00;
        rsp_ready   = '1;
        #1;
        chk("busy_idle", busy, 1'b0);
        chk("proto_err", proto_err, exp_err);
        chk("arvalid_idle", axi.arvalid, 1'b0);
    endtask

    initial begin
        // Reset values
        reset_dut();
        #1;
        chk("rst_req_ready", req_ready, 4'b0);
        chk("rst_rsp_valid", rsp_valid, 4'b0);
        chk("rst_arvalid", axi.arvalid, 1'b0);
        chk("rst_araddr", axi.araddr, 32'h0);
        chk("rst_arlen", axi.arlen, 8'h0);
        chk("rst_arid", axi.arid, 4'h0);
        chk("rst_rready", axi.rready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant_id", grant_id, 4'h0);
        chk("rst_proto_err", proto_err, 1'b0);
        chk("arsize", axi.arsize, 3'd2);
        chk("arburst", axi.arburst, 2'b01);

        // Single request, core 2, 4 beats
        do_ar(4'b0100, 2, 32'h1000, 8'd3);
        for (int b = 0; b < 4; b++) beat(2, 4'd2, 32'hA0 + b, b == 3, 2'b00, 1'b1);
        idle_chk(1'b0);

        // Backpressure: core 1 stalls three cycles on beat 2
        do_ar(4'b0010, 1, 32'h2000, 8'd3);
        beat(1, 4'd1, 32'hB0, 1'b0, 2'b00, 1'b1);
        for (int s = 0; s < 3; s++) beat(1, 4'd1, 32'hB1, 1'b0, 2'b00, 1'b0);
        beat(1, 4'd1, 32'hB1, 1'b0, 2'b00, 1'b1);
        beat(1, 4'd1, 32'hB2, 1'b0, 2'b00, 1'b1);
        beat(1, 4'd1, 32'hB3, 1'b1, 2'b00, 1'b1);
        idle_chk(1'b0);

        // Fairness: all cores request, len 0, immediate slave -> grants 0,1,2,3,0 every 3 cycles
        reset_dut();
        axi.arready = 1'b1;
        rsp_ready   = '1;
        req_len     = '0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            req_valid  = 4'hF;
            axi.rvalid = (c % 3 == 2);
            axi.rid    = 4'((c / 3) % 4);
            axi.rlast  = 1'b1;
            axi.rdata  = 32'(c);
            #1;
            chk("rr_arvalid", axi.arvalid, (c % 3 == 1));
            if (c % 3 == 0) chk("rr_req_ready", req_ready, oh((c / 3) % 4));
            if (c % 3 == 1) chk("rr_arid", axi.arid, (c / 3) % 4);
            if (c % 3 == 2) chk("rr_rsp_valid", rsp_valid, oh((c / 3) % 4));
        end
        idle_chk(1'b0);

        // SLVERR on beat 1 only
        reset_dut();
        do_ar(4'b1000, 3, 32'h3000, 8'd1);
        beat(3, 4'd3, 32'hC0, 1'b0, 2'b10, 1'b1);
        beat(3, 4'd3, 32'hC1, 1'b1, 2'b00, 1'b1);
        idle_chk(1'b0);

        // Early rlast on beat 2 of a 4-beat burst
        reset_dut();
        do_ar(4'b0001, 0, 32'h4000, 8'd3);
        beat(0, 4'd0, 32'hD0, 1'b0, 2'b00, 1'b1);
        beat(0, 4'd0, 32'hD1, 1'b1, 2'b00, 1'b1);
        idle_chk(1'b1);

        // Wrong RID
        reset_dut();
        #1 chk("err_cleared", proto_err, 1'b0);
        do_ar(4'b0001, 0, 32'h5000, 8'd0);
        beat(0, 4'd5, 32'hE0, 1'b1, 2'b00, 1'b1);
        idle_chk(1'b1);

        // Reset mid-burst during beat 2, then round-robin restarts at core 0
        reset_dut();
        do_ar(4'b0100, 2, 32'h6000, 8'd3);
        beat(2, 4'd2, 32'hF0, 1'b0, 2'b00, 1'b1);
        @(negedge clk);
        axi.arready = 1'b0;
        axi.rvalid  = 1'b1;
        axi.rid     = 4'd2;
        axi.rlast   = 1'b0;
        rst_n       = 1'b0;
        @(negedge clk);
        rst_n      = 1'b1;
        axi.rvalid = 1'b0;
        #1;
        chk("mid_busy", busy, 1'b0);
        chk("mid_arvalid", axi.arvalid, 1'b0);
        chk("mid_rready", axi.rready, 1'b0);
        chk("mid_grant_id", grant_id, 4'h0);
        chk("mid_araddr", axi.araddr, 32'h0);
        chk("mid_arlen", axi.arlen, 8'h0);
        chk("mid_rsp_valid", rsp_valid, 4'b0);
        chk("mid_proto_err", proto_err, 1'b0);
        do_ar(4'b1001, 0, 32'h7000, 8'd0);
        beat(0, 4'd0, 32'h70, 1'b1, 2'b00, 1'b1);
        idle_chk(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
